// File: rtl/vga_timing_pkg.sv
// Shared types and default 800x600@72 Hz (50 MHz pixel clock) timings for the
// raster generator and its consumers.
package vga_pkg;

    typedef logic signed [10:0] coord_t;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 56;
    localparam int H_SYNC   = 120;
    localparam int H_BP     = 64;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 37;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 23;

    localparam timing_t DEF_H = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t DEF_V = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    function automatic int span_total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel-advance enable in, coordinates and strobes out.
interface vga_timing_if;
    import vga_pkg::*;

    logic   en;
    coord_t spotX;
    coord_t spotY;
    logic   hs;
    logic   vs;
    logic   blank;
    logic   line_start;
    logic   frame_start;

    modport master (
        input  en,
        output spotX, spotY, hs, vs, blank, line_start, frame_start
    );

    modport slave (
        output en,
        input  spotX, spotY, hs, vs, blank, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_span_counter.sv
// Signed wrap counter: counts LO..HI on each step, o_wrap flags the -1 -> 0 step.
module span_counter
    import vga_pkg::*;
#(
    parameter int LO = -184,
    parameter int HI = 855
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_step,
    output coord_t o_value,
    output coord_t o_next,
    output logic   o_wrap
);

    localparam coord_t C_LO     = coord_t'(LO);
    localparam coord_t C_HI     = coord_t'(HI);
    localparam coord_t C_MINUS1 = -11'sd1;

    coord_t r_value;
    coord_t w_next;

    // next count: wrap from the top of the span into the negative porch/sync region
    always_comb begin
        w_next = r_value;
        if (i_step) begin
            if (r_value == C_HI) begin
                w_next = C_LO;
            end else begin
                w_next = r_value + 11'sd1;
            end
        end else begin
            w_next = r_value;
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= 11'sd0;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;
    assign o_next  = w_next;
    assign o_wrap  = i_step && (r_value == C_MINUS1);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator with signed spotX/spotY. Define VGA_TIMING_LOOKAHEAD_EN
// to delay all strobes one clock behind the coordinates.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   HACTIVE = H_ACTIVE,
    parameter int   HFP     = H_FP,
    parameter int   HSYNC   = H_SYNC,
    parameter int   HBP     = H_BP,
    parameter int   VACTIVE = V_ACTIVE,
    parameter int   VFP     = V_FP,
    parameter int   VSYNC   = V_SYNC,
    parameter int   VBP     = V_BP,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    vga_timing_if.master    bus
);

    if ((HACTIVE + HFP - 1 > 1023) || (HSYNC + HBP > 1024) ||
        (VACTIVE + VFP - 1 > 1023) || (VSYNC + VBP > 1024)) begin : g_param_check
        $fatal(1, "vga_timing: timing does not fit the 11-bit signed coordinate range");
    end

    localparam coord_t C_ZERO   = 11'sd0;
    localparam coord_t HS_START = coord_t'(-(HSYNC + HBP));
    localparam coord_t HS_END   = coord_t'(-HBP);
    localparam coord_t VS_START = coord_t'(-(VSYNC + VBP));
    localparam coord_t VS_END   = coord_t'(-VBP);
    localparam coord_t H_ACT    = coord_t'(HACTIVE);
    localparam coord_t V_ACT    = coord_t'(VACTIVE);

    coord_t w_h_value, w_h_next, w_v_value, w_v_next;
    logic   w_h_wrap, w_v_wrap;
    logic   w_hs, w_vs, w_blank;
    logic   r_hs, r_vs, r_blank, r_line, r_frame;

    span_counter #(.LO(-(HSYNC + HBP)), .HI(HACTIVE + HFP - 1)) u_h_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  (bus.en),
        .o_value (w_h_value),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    // the line counter advances exactly when spotX wraps into 0
    span_counter #(.LO(-(VSYNC + VBP)), .HI(VACTIVE + VFP - 1)) u_v_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  (w_h_wrap),
        .o_value (w_v_value),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // decode strobes from the next-state counters so they register alongside spotX/spotY
    always_comb begin
        w_hs    = ~HS_POL;
        w_vs    = ~VS_POL;
        w_blank = 1'b0;
        if ((w_h_next >= HS_START) && (w_h_next < HS_END)) begin
            w_hs = HS_POL;
        end else begin
            w_hs = ~HS_POL;
        end
        if ((w_v_next >= VS_START) && (w_v_next < VS_END)) begin
            w_vs = VS_POL;
        end else begin
            w_vs = ~VS_POL;
        end
        w_blank = (w_h_next < C_ZERO) || (w_h_next >= H_ACT) ||
                  (w_v_next < C_ZERO) || (w_v_next >= V_ACT);
    end

    // strobe registers; pulses are qualified by the step itself so en=0 clears them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_blank <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_hs    <= w_hs;
            r_vs    <= w_vs;
            r_blank <= w_blank;
            r_line  <= w_h_wrap;
            r_frame <= w_v_wrap;
        end
    end

    assign bus.spotX = w_h_value;
    assign bus.spotY = w_v_value;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic r_hs_d, r_vs_d, r_blank_d, r_line_d, r_frame_d;

    // extra strobe stage for colour generators that register one clock after sampling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d    <= ~HS_POL;
            r_vs_d    <= ~VS_POL;
            r_blank_d <= 1'b0;
            r_line_d  <= 1'b0;
            r_frame_d <= 1'b0;
        end else begin
            r_hs_d    <= r_hs;
            r_vs_d    <= r_vs;
            r_blank_d <= r_blank;
            r_line_d  <= r_line;
            r_frame_d <= r_frame;
        end
    end

    assign bus.hs          = r_hs_d;
    assign bus.vs          = r_vs_d;
    assign bus.blank       = r_blank_d;
    assign bus.line_start  = r_line_d;
    assign bus.frame_start = r_frame_d;
`else
    assign bus.hs          = r_hs;
    assign bus.vs          = r_vs;
    assign bus.blank       = r_blank;
    assign bus.line_start  = r_line;
    assign bus.frame_start = r_frame;
`endif

endmodule
